csr_timer_bank: RTL

//  Parametrised CSR timer bank; next generation of the single TCFG/TVAL/TICLR timer in the CSR unit.

---
 rtl/csr_pkg.sv | 19 +
 rtl/timer_channel.sv | 58 +++++
 rtl/csr_timer_bank.sv | 100 ++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared CSR unit definitions: timer register addresses and field positions.
// Reused by the CSR file and the timer bank so both decode identically.
package csr_pkg;

  localparam logic [13:0] TCFG_ADDR  = 14'h041;
  localparam logic [13:0] TVAL_ADDR  = 14'h042;
  localparam logic [13:0] TICLR_ADDR = 14'h044;

  localparam int TCFG_EN          = 0;
  localparam int TCFG_PERIODIC    = 1;
  localparam int TCFG_INITVAL_LSB = 2;
  localparam int TICLR_CLR        = 0;

  function automatic logic [13:0] ch_addr(input logic [13:0] base, input int ch,
                                          input logic [13:0] stride);
    return base + 14'(ch) * stride;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown timer channel: TCFG, live TVAL, run flag and pending irq.
// Registers update one cycle after the strobe; there is no backpressure.
module timer_channel
  import csr_pkg::*;
#(
  parameter int TVAL_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr_tcfg,
  input  logic              wr_ticlr,
  input  logic [TVAL_W-1:0] wdata,
  output logic [TVAL_W-1:0] tcfg,
  output logic [TVAL_W-1:0] tval,
  output logic              irq
);

  logic run;
  logic tval_zero;
  logic expire;

  assign tval_zero = (tval == '0);
  // A TCFG write in the same cycle swallows the tick, so it can never expire.
  assign expire    = tick && run && !wr_tcfg && tval_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg <= '0;
      tval <= '1;
      run  <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (wr_tcfg) begin
        tcfg <= wdata;
        tval <= {wdata[TVAL_W-1:TCFG_INITVAL_LSB], 2'b00};
        run  <= wdata[TCFG_EN];
      end else if (tick && run) begin
        if (!tval_zero) begin
          tval <= tval - 1'b1;
        end else if (tcfg[TCFG_PERIODIC]) begin
          tval <= {tcfg[TVAL_W-1:TCFG_INITVAL_LSB], 2'b00};
        end else begin
          tval <= '1;
          run  <= 1'b0;
        end
      end

      // Expiry beats a simultaneous clear so no interrupt is ever lost.
      if (expire) begin
        irq <= 1'b1;
      end else if (wr_ticlr && wdata[TICLR_CLR]) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/csr_timer_bank.sv
// Bank of N countdown timers with shared prescaler and free-running stable counter.
// CSR reads are combinational; writes land the following cycle; no backpressure.
module csr_timer_bank
  import csr_pkg::*;
#(
  parameter int          N_TIMERS  = 1,
  parameter int          TVAL_W    = 32,
  parameter int          CNT_W     = 64,
  parameter int          PRESCALE  = 1,
  parameter logic [13:0] CH_STRIDE = 14'h10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                csr_we,
  input  logic [13:0]         csr_addr,
  input  logic [31:0]         csr_wdata,
  output logic                csr_hit,
  output logic [31:0]         csr_rdata,
  output logic [N_TIMERS-1:0] timer_irq,
  output logic [CNT_W-1:0]    stable_cnt
);

  logic                tick;
  logic [N_TIMERS-1:0] wr_tcfg;
  logic [N_TIMERS-1:0] wr_ticlr;
  logic [TVAL_W-1:0]   ch_tcfg [N_TIMERS];
  logic [TVAL_W-1:0]   ch_tval [N_TIMERS];

  generate
    if (PRESCALE > 1) begin : g_prescale
      localparam int PS_W = $clog2(PRESCALE);
      localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
      logic [PS_W-1:0] ps_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          ps_q <= '0;
        end else if (ps_q == PS_LAST) begin
          ps_q <= '0;
        end else begin
          ps_q <= ps_q + 1'b1;
        end
      end

      assign tick = (ps_q == PS_LAST);
    end else begin : g_no_prescale
      assign tick = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Decode and read mux share one loop; unmatched addresses fall through to hit=0, rdata=0.
  always_comb begin
    csr_hit   = 1'b0;
    csr_rdata = '0;
    wr_tcfg   = '0;
    wr_ticlr  = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      if (csr_addr == ch_addr(TCFG_ADDR, i, CH_STRIDE)) begin
        csr_hit    = 1'b1;
        csr_rdata  = 32'(ch_tcfg[i]);
        wr_tcfg[i] = csr_we;
      end
      if (csr_addr == ch_addr(TVAL_ADDR, i, CH_STRIDE)) begin
        csr_hit   = 1'b1;
        csr_rdata = 32'(ch_tval[i]);
      end
      if (csr_addr == ch_addr(TICLR_ADDR, i, CH_STRIDE)) begin
        csr_hit     = 1'b1;
        wr_ticlr[i] = csr_we;
      end
    end
  end

  generate
    for (genvar g = 0; g < N_TIMERS; g++) begin : g_ch
      timer_channel #(
        .TVAL_W (TVAL_W)
      ) u_ch (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .wr_tcfg  (wr_tcfg[g]),
        .wr_ticlr (wr_ticlr[g]),
        .wdata    (csr_wdata[TVAL_W-1:0]),
        .tcfg     (ch_tcfg[g]),
        .tval     (ch_tval[g]),
        .irq      (timer_irq[g])
      );
    end
  endgenerate

endmodule
